// File: rtl/rram_op_sequencer.sv
`default_nettype none
//==============================================================================
// Module : rram_op_sequencer
// Brief  : Runs one RRAM crossbar WRITE/READ/MAC operation at a time, driving
//          the line-driver controls and returning CSA/ADC results.
// Rev    : 1.0  initial release
//==============================================================================

module rram_op_sequencer #(
    parameter int ARRAY_SIZE = 16,
    parameter int ROW_W      = 4,
    parameter int PRE_CYCLES = 2,
    parameter int DRV_CYCLES = 4,
    parameter int WR_CYCLES  = 8,
    parameter int ADC_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ROW_W-1:0]        cmd_row,
    input  logic [ARRAY_SIZE-1:0]   cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [3*ARRAY_SIZE-1:0] rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    PRE,
    output logic                    ENABLE_WL,
    output logic                    ENABLE_BL,
    output logic                    ENABLE_SL,
    output logic                    ENABLE_CSA,
    output logic                    ENABLE_ADC,
    output logic                    SAEN_CSA,
    output logic [1:0]              CLK_EN_ADC,
    output logic [ARRAY_SIZE-1:0]   IN0_WL,
    output logic [ARRAY_SIZE-1:0]   IN1_WL,
    output logic [ARRAY_SIZE-1:0]   IN0_BL,
    output logic [ARRAY_SIZE-1:0]   IN1_BL,
    output logic [ARRAY_SIZE-1:0]   IN0_SL,
    output logic [ARRAY_SIZE-1:0]   IN1_SL,
    input  logic [ARRAY_SIZE-1:0]   CSA,
    input  logic [ARRAY_SIZE-1:0]   ADC_OUT0,
    input  logic [ARRAY_SIZE-1:0]   ADC_OUT1,
    input  logic [ARRAY_SIZE-1:0]   ADC_OUT2
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PRE   = 3'd1;
    localparam logic [2:0] c_ST_DRIVE = 3'd2;
    localparam logic [2:0] c_ST_SENSE = 3'd3;
    localparam logic [2:0] c_ST_RESP  = 3'd4;

    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_READ  = 2'b10;
    localparam logic [1:0] c_OP_MAC   = 2'b11;

    localparam int c_MAX_A   = (PRE_CYCLES > DRV_CYCLES) ? PRE_CYCLES : DRV_CYCLES;
    localparam int c_MAX_B   = (WR_CYCLES > ADC_CYCLES) ? WR_CYCLES : ADC_CYCLES;
    localparam int c_CNT_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_RAW = $clog2(c_CNT_MAX);
    // At least two bits so the ADC clock phase can be taken from the count.
    localparam int c_CNT_W   = (c_CNT_RAW < 2) ? 2 : c_CNT_RAW;

    localparam logic [c_CNT_W-1:0] c_PRE_LAST = c_CNT_W'(PRE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DRV_LAST = c_CNT_W'(DRV_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LAST  = c_CNT_W'(WR_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ADC_LAST = c_CNT_W'(ADC_CYCLES - 1);
    localparam logic [ARRAY_SIZE-1:0] c_ONE   = ARRAY_SIZE'(1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nx;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nx;
    logic [1:0]            r_op;
    logic [ROW_W-1:0]      r_row;
    logic [ARRAY_SIZE-1:0] r_data;
    logic [1:0]            w_op_nx;
    logic [ROW_W-1:0]      w_row_nx;
    logic [ARRAY_SIZE-1:0] w_data_nx;
    logic                  w_accept;
    logic                  w_row_oor;
    logic                  w_cmd_err;

    logic [3*ARRAY_SIZE-1:0] r_rsp_data;
    logic                    r_rsp_err;

    logic                  w_pre, w_en_wl, w_en_bl, w_en_sl, w_en_csa, w_en_adc, w_saen;
    logic [1:0]            w_clk_en;
    logic [ARRAY_SIZE-1:0] w_in0_wl, w_in1_wl, w_in0_bl, w_in1_bl, w_in0_sl, w_in1_sl;
    logic [ARRAY_SIZE-1:0] w_row_hot;

    logic                  r_pre, r_en_wl, r_en_bl, r_en_sl, r_en_csa, r_en_adc, r_saen;
    logic [1:0]            r_clk_en;
    logic [ARRAY_SIZE-1:0] r_in0_wl, r_in1_wl, r_in0_bl, r_in1_bl, r_in0_sl, r_in1_sl;

    // A narrow row field cannot address past the array, so no compare is built.
    generate
        if ((1 << ROW_W) > ARRAY_SIZE) begin : g_row_chk
            assign w_row_oor = (32'(cmd_row) >= 32'(ARRAY_SIZE));
        end else begin : g_row_nochk
            assign w_row_oor = 1'b0;
        end
    endgenerate

    assign cmd_ready = (r_state == c_ST_IDLE) && !rst;
    assign busy      = (r_state != c_ST_IDLE);
    assign rsp_valid = (r_state == c_ST_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    assign w_accept  = cmd_valid && (r_state == c_ST_IDLE);
    assign w_cmd_err = w_row_oor && ((cmd_op == c_OP_WRITE) || (cmd_op == c_OP_READ));
    assign w_op_nx   = w_accept ? cmd_op   : r_op;
    assign w_row_nx  = w_accept ? cmd_row  : r_row;
    assign w_data_nx = w_accept ? cmd_data : r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_op    <= c_OP_NOP;
            r_row   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_op    <= w_op_nx;
            r_row   <= w_row_nx;
            r_data  <= w_data_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_NOP:   w_state_nx = c_ST_IDLE;
                        c_OP_WRITE: w_state_nx = w_cmd_err ? c_ST_RESP : c_ST_DRIVE;
                        c_OP_READ:  w_state_nx = w_cmd_err ? c_ST_RESP : c_ST_PRE;
                        c_OP_MAC:   w_state_nx = c_ST_PRE;
                        default:    w_state_nx = c_ST_IDLE;
                    endcase
                end
            end
            c_ST_PRE: begin
                if (r_cnt == c_PRE_LAST) w_state_nx = c_ST_DRIVE;
            end
            c_ST_DRIVE: begin
                if (r_op == c_OP_WRITE) begin
                    if (r_cnt == c_WR_LAST) w_state_nx = c_ST_RESP;
                end else if (r_cnt == c_DRV_LAST) begin
                    w_state_nx = c_ST_SENSE;
                end
            end
            c_ST_SENSE: begin
                if ((r_op == c_OP_READ) || (r_cnt == c_ADC_LAST)) w_state_nx = c_ST_RESP;
            end
            c_ST_RESP: begin
                if (rsp_ready) w_state_nx = c_ST_IDLE;
            end
            default: w_state_nx = c_ST_IDLE;
        endcase

        // Count restarts on each state entry and only advances in timed states.
        if (w_state_nx != r_state) begin
            w_cnt_nx = '0;
        end else if ((r_state == c_ST_PRE) || (r_state == c_ST_DRIVE) ||
                     (r_state == c_ST_SENSE)) begin
            w_cnt_nx = r_cnt + 1'b1;
        end
    end

    // Controls are decoded from the upcoming state so the registered pins line up with it.
    always_comb begin
        w_pre     = 1'b0;
        w_en_wl   = 1'b0;
        w_en_bl   = 1'b0;
        w_en_sl   = 1'b0;
        w_en_csa  = 1'b0;
        w_en_adc  = 1'b0;
        w_saen    = 1'b0;
        w_clk_en  = 2'b00;
        w_in0_wl  = '0;
        w_in1_wl  = '0;
        w_in0_bl  = '0;
        w_in1_bl  = '0;
        w_in0_sl  = '0;
        w_in1_sl  = '0;
        w_row_hot = c_ONE << w_row_nx;

        if (w_state_nx == c_ST_PRE) w_pre = 1'b1;

        if ((w_state_nx == c_ST_DRIVE) || (w_state_nx == c_ST_SENSE)) begin
            w_en_wl = 1'b1;
            w_en_bl = 1'b1;
            w_en_sl = 1'b1;
            case (w_op_nx)
                c_OP_WRITE: begin
                    w_in1_wl = w_row_hot;
                    w_in1_bl = w_data_nx;
                    w_in0_sl = ~w_data_nx;
                    w_in1_sl = ~w_data_nx;
                end
                c_OP_READ: begin
                    w_in0_wl = w_row_hot;
                    w_in0_bl = '1;
                end
                default: begin
                    w_in0_wl = w_data_nx;
                    w_in0_bl = '1;
                end
            endcase
        end

        if (w_state_nx == c_ST_SENSE) begin
            if (w_op_nx == c_OP_READ) begin
                w_en_csa = 1'b1;
                w_saen   = 1'b1;
            end else begin
                w_en_adc = 1'b1;
                w_clk_en = w_cnt_nx[1:0] + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre    <= 1'b0;
            r_en_wl  <= 1'b0;
            r_en_bl  <= 1'b0;
            r_en_sl  <= 1'b0;
            r_en_csa <= 1'b0;
            r_en_adc <= 1'b0;
            r_saen   <= 1'b0;
            r_clk_en <= 2'b00;
            r_in0_wl <= '0;
            r_in1_wl <= '0;
            r_in0_bl <= '0;
            r_in1_bl <= '0;
            r_in0_sl <= '0;
            r_in1_sl <= '0;
        end else begin
            r_pre    <= w_pre;
            r_en_wl  <= w_en_wl;
            r_en_bl  <= w_en_bl;
            r_en_sl  <= w_en_sl;
            r_en_csa <= w_en_csa;
            r_en_adc <= w_en_adc;
            r_saen   <= w_saen;
            r_clk_en <= w_clk_en;
            r_in0_wl <= w_in0_wl;
            r_in1_wl <= w_in1_wl;
            r_in0_bl <= w_in0_bl;
            r_in1_bl <= w_in1_bl;
            r_in0_sl <= w_in0_sl;
            r_in1_sl <= w_in1_sl;
        end
    end

    assign PRE        = r_pre;
    assign ENABLE_WL  = r_en_wl;
    assign ENABLE_BL  = r_en_bl;
    assign ENABLE_SL  = r_en_sl;
    assign ENABLE_CSA = r_en_csa;
    assign ENABLE_ADC = r_en_adc;
    assign SAEN_CSA   = r_saen;
    assign CLK_EN_ADC = r_clk_en;
    assign IN0_WL     = r_in0_wl;
    assign IN1_WL     = r_in1_wl;
    assign IN0_BL     = r_in0_bl;
    assign IN1_BL     = r_in1_bl;
    assign IN0_SL     = r_in0_sl;
    assign IN1_SL     = r_in1_sl;

    // Result is captured on the edge that leaves SENSE and cleared on acceptance/handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (w_accept) begin
            r_rsp_data <= '0;
            r_rsp_err  <= w_cmd_err;
        end else if ((r_state == c_ST_SENSE) && (w_state_nx == c_ST_RESP)) begin
            r_rsp_data <= (r_op == c_OP_READ) ? {{(2*ARRAY_SIZE){1'b0}}, CSA}
                                              : {ADC_OUT2, ADC_OUT1, ADC_OUT0};
        end else if (rsp_valid && rsp_ready) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rram_op_sequencer.sv
`default_nettype none
//==============================================================================
// Module : tb_rram_op_sequencer
// Brief  : Self-checking bench for rram_op_sequencer (command table + corner cases).
// Rev    : 1.0  initial release
//==============================================================================

module tb_rram_op_sequencer;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [4:0]    cmd_row;
    logic [N-1:0]  cmd_data;
    logic          rsp_valid, rsp_ready;
    logic [3*N-1:0] rsp_data;
    logic          rsp_err, busy;
    logic          PRE, ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, ENABLE_ADC, SAEN_CSA;
    logic [1:0]    CLK_EN_ADC;
    logic [N-1:0]  IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL;
    logic [N-1:0]  CSA, ADC_OUT0, ADC_OUT1, ADC_OUT2;

    rram_op_sequencer #(.ARRAY_SIZE(N), .ROW_W(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .PRE(PRE), .ENABLE_WL(ENABLE_WL), .ENABLE_BL(ENABLE_BL), .ENABLE_SL(ENABLE_SL),
        .ENABLE_CSA(ENABLE_CSA), .ENABLE_ADC(ENABLE_ADC), .SAEN_CSA(SAEN_CSA),
        .CLK_EN_ADC(CLK_EN_ADC),
        .IN0_WL(IN0_WL), .IN1_WL(IN1_WL), .IN0_BL(IN0_BL), .IN1_BL(IN1_BL),
        .IN0_SL(IN0_SL), .IN1_SL(IN1_SL),
        .CSA(CSA), .ADC_OUT0(ADC_OUT0), .ADC_OUT1(ADC_OUT1), .ADC_OUT2(ADC_OUT2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  row;
        logic [15:0] data;
        logic [15:0] csa, a2, a1, a0;
        int          hold;
        int          poke;
        int          lat;
        logic [47:0] rdata;
        logic        err;
        int          n_pre, n_en, n_saen, n_adc;
    } vec_t;

    typedef struct {
        logic [47:0] rdata;
        logic        err;
        int          lat, n_pre, n_en, n_saen, n_adc;
    } exp_t;

    vec_t tbl[9];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   e0 = 0;

    logic any_arr;
    assign any_arr = PRE | ENABLE_WL | ENABLE_BL | ENABLE_SL | ENABLE_CSA | ENABLE_ADC |
                     SAEN_CSA | (|CLK_EN_ADC) | (|IN0_WL) | (|IN1_WL) | (|IN0_BL) |
                     (|IN1_BL) | (|IN0_SL) | (|IN1_SL);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line levels a correct sequencer must present while the line enables are on.
    function automatic logic [95:0] line_model(input logic [1:0] op, input logic [4:0] row,
                                               input logic [15:0] d);
        logic [15:0] hot;
        hot = 16'h0001 << row;
        case (op)
            2'b01:   return {hot, 16'h0, d, 16'h0, ~d, ~d};
            2'b10:   return {16'h0, hot, 16'h0, 16'hFFFF, 32'h0};
            2'b11:   return {16'h0, d, 16'h0, 16'hFFFF, 32'h0};
            default: return 96'h0;
        endcase
    endfunction

    task automatic send(input logic [1:0] op, input logic [4:0] row, input logic [15:0] data);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_before_send", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = row;
        cmd_data  = data;
        @(posedge clk);
        #1;
        e0        = cyc;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_row   = ~row;
        cmd_data  = ~data;
    endtask

    task automatic run_cmd(input vec_t v);
        exp_t        e;
        int          n_pre, n_en, n_saen, n_adc, bad_line, bad_ctl, bad_hold, lat;
        bit          got;
        logic [95:0] lm, lines;
        logic [47:0] d0;
        n_pre = 0; n_en = 0; n_saen = 0; n_adc = 0;
        bad_line = 0; bad_ctl = 0; bad_hold = 0; lat = -1; got = 0;
        CSA = v.csa; ADC_OUT2 = v.a2; ADC_OUT1 = v.a1; ADC_OUT0 = v.a0;
        send(v.op, v.row, v.data);
        sb.push_back('{rdata: v.rdata, err: v.err, lat: v.lat, n_pre: v.n_pre,
                       n_en: v.n_en, n_saen: v.n_saen, n_adc: v.n_adc});
        lm = line_model(v.op, v.row, v.data);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (v.poke > 0 && i == v.poke) begin
                cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 16'hFFFF;
            end else begin
                cmd_valid = 1'b0;
            end
            lines = {IN1_WL, IN0_WL, IN1_BL, IN0_BL, IN1_SL, IN0_SL};
            if (PRE) n_pre++;
            if (ENABLE_WL) n_en++;
            if (ENABLE_BL !== ENABLE_WL || ENABLE_SL !== ENABLE_WL) bad_ctl++;
            if (PRE && ENABLE_WL) bad_ctl++;
            if (lines !== (ENABLE_WL ? lm : 96'h0)) bad_line++;
            if (SAEN_CSA) n_saen++;
            if (SAEN_CSA !== ENABLE_CSA) bad_ctl++;
            if (ENABLE_ADC) begin
                if (CLK_EN_ADC !== 2'(n_adc + 1)) bad_ctl++;
                n_adc++;
            end else if (CLK_EN_ADC !== 2'b00) begin
                bad_ctl++;
            end
            if (rsp_valid) begin
                got = 1;
                lat = cyc - e0;
            end
        end
        cmd_valid = 1'b0;
        chk("rsp_timeout", got, 1);
        if (got) begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("latency", lat, e.lat);
            chk("pre_cycles", n_pre, e.n_pre);
            chk("line_en_cycles", n_en, e.n_en);
            chk("saen_pulses", n_saen, e.n_saen);
            chk("adc_cycles", n_adc, e.n_adc);
            chk("line_levels_bad", bad_line, 0);
            chk("ctl_seq_bad", bad_ctl, 0);
            d0 = rsp_data;
            for (int h = 0; h < v.hold; h++) begin
                CSA = 16'($urandom); ADC_OUT0 = 16'($urandom);
                @(negedge clk);
                if (!rsp_valid || rsp_data !== d0) bad_hold++;
            end
            if (v.hold > 0) chk("rsp_hold_bad", bad_hold, 0);
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            chk("idle_after_hs", {cmd_ready, busy, rsp_valid}, 3'b100);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bad;
        tbl[0] = '{op:2'b01, row:5'd5,  data:16'hA5A5, csa:16'h0,    a2:16'h0,    a1:16'h0,    a0:16'h0,
                   hold:0, poke:0, lat:8, rdata:48'h0, err:1'b0, n_pre:0, n_en:8, n_saen:0, n_adc:0};
        tbl[1] = '{op:2'b10, row:5'd1,  data:16'h0,    csa:16'h1234, a2:16'h0,    a1:16'h0,    a0:16'h0,
                   hold:3, poke:0, lat:7, rdata:48'h1234, err:1'b0, n_pre:2, n_en:5, n_saen:1, n_adc:0};
        tbl[2] = '{op:2'b11, row:5'd0,  data:16'h00F0, csa:16'h0,    a2:16'h0001, a1:16'h0002, a0:16'h0003,
                   hold:0, poke:0, lat:9, rdata:48'h0001_0002_0003, err:1'b0, n_pre:2, n_en:7, n_saen:0, n_adc:3};
        tbl[3] = '{op:2'b10, row:5'd15, data:16'h0,    csa:16'hBEEF, a2:16'h0,    a1:16'h0,    a0:16'h0,
                   hold:0, poke:0, lat:7, rdata:48'hBEEF, err:1'b0, n_pre:2, n_en:5, n_saen:1, n_adc:0};
        tbl[4] = '{op:2'b10, row:5'd20, data:16'h0,    csa:16'hFFFF, a2:16'h0,    a1:16'h0,    a0:16'h0,
                   hold:0, poke:0, lat:0, rdata:48'h0, err:1'b1, n_pre:0, n_en:0, n_saen:0, n_adc:0};
        tbl[5] = '{op:2'b01, row:5'd16, data:16'hFFFF, csa:16'h0,    a2:16'h0,    a1:16'h0,    a0:16'h0,
                   hold:0, poke:0, lat:0, rdata:48'h0, err:1'b1, n_pre:0, n_en:0, n_saen:0, n_adc:0};
        tbl[6] = '{op:2'b11, row:5'd31, data:16'hFFFF, csa:16'h0,    a2:16'hAAAA, a1:16'h5555, a0:16'h0F0F,
                   hold:2, poke:0, lat:9, rdata:48'hAAAA_5555_0F0F, err:1'b0, n_pre:2, n_en:7, n_saen:0, n_adc:3};
        tbl[7] = '{op:2'b01, row:5'd0,  data:16'h0000, csa:16'h0,    a2:16'h0,    a1:16'h0,    a0:16'h0,
                   hold:0, poke:0, lat:8, rdata:48'h0, err:1'b0, n_pre:0, n_en:8, n_saen:0, n_adc:0};
        tbl[8] = '{op:2'b10, row:5'd2,  data:16'h0,    csa:16'h00FF, a2:16'h0,    a1:16'h0,    a0:16'h0,
                   hold:0, poke:3, lat:7, rdata:48'h00FF, err:1'b0, n_pre:2, n_en:5, n_saen:1, n_adc:0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_row = '0; cmd_data = '0;
        rsp_ready = 1'b0; CSA = '0; ADC_OUT0 = '0; ADC_OUT1 = '0; ADC_OUT2 = '0;

        // Reset state, then release.
        repeat (3) @(negedge clk);
        chk("in_reset_outputs", {any_arr, cmd_ready, rsp_valid, busy}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_array_outputs", any_arr, 0);
        chk("reset_busy", busy, 0);

        // NOP is consumed with no response.
        send(2'b00, 5'd3, 16'h1111);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || rsp_valid || !cmd_ready || any_arr) bad++;
        end
        chk("nop_no_activity", bad, 0);

        for (int k = 0; k < 9; k++) run_cmd(tbl[k]);

        // Asynchronous reset during DRIVE of a WRITE.
        send(2'b01, 5'd3, 16'h1234);
        repeat (3) @(negedge clk);
        chk("mid_write_enable", ENABLE_WL, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {any_arr, rsp_valid, busy}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || busy || any_arr) bad++;
        end
        chk("no_rsp_after_reset", bad, 0);

        run_cmd(tbl[1]);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rram_op_sequencer.md
Name: rram_op_sequencer

Overview:
- Sequences one RRAM crossbar operation at a time (WRITE, READ, MAC) from a command handshake.
- Drives the array line-driver controls: WL/BL/SL enables, IN0/IN1 level selects, PRE, SAEN_CSA, CLK_EN_ADC.
- Captures CSA or ADC results and returns them on a response handshake.
- Sits between the instruction-decode side of RRAM_CONTROLLER and the analog macro pins.

Parameters:
ARRAY_SIZE, 16, rows/columns of crossbar; width of every line bus
ROW_W, 4, width of cmd_row
PRE_CYCLES, 2, cycles in PRECHARGE (>=1)
DRV_CYCLES, 4, read/MAC line-settle cycles in DRIVE (>=1)
WR_CYCLES, 8, write-pulse cycles in DRIVE for WRITE (>=1)
ADC_CYCLES, 3, cycles in SENSE for MAC (1..3)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 MAC
cmd_row  in  ROW_W  target row (WRITE/READ)
cmd_data  in  ARRAY_SIZE  write data (WRITE) or WL input vector (MAC)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  3*ARRAY_SIZE  result payload
rsp_err  out  1  row out of range
busy  out  1  state != IDLE
PRE, ENABLE_WL, ENABLE_BL, ENABLE_SL, ENABLE_CSA, ENABLE_ADC, SAEN_CSA  out  1 each  array controls
CLK_EN_ADC  out  2  ADC clock enable phase
IN0_WL, IN1_WL, IN0_BL, IN1_BL, IN0_SL, IN1_SL  out  ARRAY_SIZE each  per-line level select
CSA  in  ARRAY_SIZE  sense-amp outputs
ADC_OUT0, ADC_OUT1, ADC_OUT2  in  ARRAY_SIZE each  ADC bit-planes

Behaviour:
- Line level per line i, {IN1[i],IN0[i]}: 00 ground, 01 read bias, 10 set, 11 reset.
- Reset (async, any state): state IDLE, all outputs 0, except cmd_ready which is 1 after reset release. A pending response is discarded.
- All array outputs are registered. Outside the states listed below they are 0.
- FSM states: IDLE, PRECHARGE, DRIVE, SENSE, RESP.
- IDLE: accept on cmd_valid & cmd_ready (edge E0).
  - NOP: consumed, no response, stays IDLE.
  - WRITE: go to DRIVE.
  - READ or MAC: go to PRECHARGE.
  - cmd_row and cmd_data are latched at E0. Later input changes are ignored.
- PRECHARGE: PRE=1 for PRE_CYCLES cycles, then DRIVE.
- DRIVE, WRITE:
  - ENABLE_WL/BL/SL=1. Row WL = 10, others 00.
  - Bit i=1: BL[i]=10, SL[i]=00. Bit i=0: BL[i]=00, SL[i]=11.
  - Lasts WR_CYCLES, then RESP with rsp_data=0.
- DRIVE, READ: ENABLE_WL/BL/SL=1. Row WL=01, all BL=01, all SL=00. Lasts DRV_CYCLES, then SENSE.
- DRIVE, MAC: same as READ except WL[i]=01 where cmd_data[i]=1, else 00.
- SENSE: line drives held as in DRIVE.
  - READ: ENABLE_CSA=1 and SAEN_CSA=1 for 1 cycle. CSA is sampled at the exit edge. rsp_data = {0, CSA}.
  - MAC: ENABLE_ADC=1 for ADC_CYCLES cycles. CLK_EN_ADC = k+1 in SENSE cycle k (01, 10, 11). ADC outputs are sampled at the exit edge. rsp_data = {ADC_OUT2, ADC_OUT1, ADC_OUT0}.
- RESP: rsp_valid=1 and rsp_data/rsp_err stable until rsp_valid & rsp_ready, then IDLE. cmd_ready=1 the cycle after the handshake, so back-to-back commands are spaced by 1 IDLE cycle.
- Latency with defaults, counted in edges after E0 until rsp_valid is high: WRITE 8, READ 7, MAC 9.
- rsp_err: cmd_row >= ARRAY_SIZE on WRITE/READ.
  - Skip PRECHARGE/DRIVE/SENSE and go to RESP with rsp_err=1, rsp_data=0, no array activity.
  - MAC ignores cmd_row.
- State counter is reloaded on every state entry and never wraps.
- cmd_valid during non-IDLE is ignored (cmd_ready=0).

Test Plan:
- Reset in IDLE, then release -> all array outputs 0, cmd_ready=1, rsp_valid=0.
- WRITE row=5, data=16'hA5A5 -> 8 cycles of ENABLE_WL/BL/SL=1, IN1_WL=16'h0020, IN0_WL=0, IN1_BL=16'hA5A5, IN0_SL=IN1_SL=16'h5A5A. Then rsp_valid with rsp_data=0 and rsp_err=0.
- READ row=1 with CSA=16'h1234 -> PRE=1 for 2 cycles, 4 DRIVE cycles with IN0_WL=16'h0002 and IN0_BL=16'hFFFF, 1 SAEN_CSA pulse. rsp_data=48'h1234 at edge 7. Hold rsp_ready=0 for 3 cycles -> rsp_data unchanged.
- MAC cmd_data=16'h00F0 with ADC_OUT2/1/0 = 16'h0001/16'h0002/16'h0003 -> IN0_WL=16'h00F0, CLK_EN_ADC sequence 01, 10, 11, rsp_data=48'h0001_0002_0003 at edge 9.
- Assert rst during DRIVE of a WRITE -> all line buses and enables 0 in the same cycle (async), state IDLE, no rsp_valid after release.
- With ROW_W=5, READ row=20 -> no PRE/enable activity, rsp_err=1 next cycle. Also: NOP consumed with no response, and a cmd_valid pulse while busy is not accepted.
